largest_num_divisible_by_k: RTL and testbench
=============================================

# largest_num_divisible_by_k

Parametrised successor to the fixed 16×8-bit divisible-by-7 search engine. It holds DEPTH unsigned WIDTH-bit numbers in an internal array, which a host writes through a simple write port. On Start it scans the array and tests divisibility by DIVISOR using repeated subtraction. It reports the largest or smallest non-zero multiple (selected per run), that multiple's index, and the count of non-zero multiples found, then waits for Ack.

## Interface
- WIDTH, 8, data width of each array entry and of Result.
- DEPTH, 16, number of array entries; power of two, ≥ 2; ADDR_W = clog2(DEPTH) is derived.
- DIVISOR, 7, constant divisor; 2 ≤ DIVISOR ≤ 2^WIDTH−1.
- Clk  in  1  single clock, rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- Start  in  1  begin scan; sampled in INI only.
- Ack  in  1  acknowledge result; sampled in D_F/D_NF only.
- Find_Min  in  1  0 = largest, 1 = smallest multiple; latched in INI when Start=1.
- Wr_En  in  1  array write strobe; honoured in INI only.
- Wr_Addr  in  ADDR_W  write index.
- Wr_Data  in  WIDTH  write value.
- Result  out  WIDTH  selected multiple; 0 when none found.
- Result_Idx  out  ADDR_W  index of Result.
- Count  out  ADDR_W+1  number of non-zero multiples found.
- Done  out  1  Qdf | Qdnf.
- Qi, Ql, Qdiv, Qdf, Qdnf  out  1 each  one-hot state bits for INI, LD_X, DIV, D_F and D_NF.

## Operation
- States are one-hot 5-bit: INI=00001, LD_X=00010, DIV=00100, D_F=01000, D_NF=10000.
- **INI**
  - Every cycle: Result←0, Result_Idx←0, Count←0, I←0.
  - Wr_En=1: M[Wr_Addr]←Wr_Data.
  - Start=1: Mode←Find_Min; go to LD_X.
- **LD_X**: X←M[I]; go to DIV.
- **DIV**, while X ≥ DIVISOR: X←X−DIVISOR; stay in DIV.
- **DIV**, when X < DIVISOR: evaluate M[I].
  - A hit is X==0 and M[I]≠0.
  - On a hit: Count←Count+1.
  - On a hit that is better: Result←M[I], Result_Idx←I.
    - Better means Count==0, or M[I] > Result when Mode=0, or M[I] < Result when Mode=1.
    - The comparison is strict, so on ties the earliest index is kept.
  - If I==DEPTH−1: go to D_F if (Count≠0 or hit this cycle), else go to D_NF.
  - Otherwise: I←I+1; go to LD_X.
- **D_F / D_NF**: outputs hold. Ack=1 → INI. Start, Wr_En and Find_Min are ignored here.
- Zero entries never count as hits. Entries equal to DIVISOR are hits.
- Arithmetic is unsigned WIDTH-bit. The subtraction cannot underflow because it only happens when X ≥ DIVISOR.

## Timing
- Reset (Reset_n=0 at a rising edge) puts the block in INI with Result=0, Result_Idx=0, Count=0, Done=0 and Qi=1.
- Reset mid-scan aborts the scan on that edge. Array contents are not reset and are preserved.
- Per-entry latency is 1 (LD_X) + floor(M[I]/DIVISOR) + 1 (DIV) cycles.
- Total scan time is the sum of per-entry latencies over all entries, plus 1 cycle leaving INI.
- Done rises in the cycle after the final DIV evaluation. Result, Result_Idx and Count are stable while Done=1.
- Wr_En and Start in the same INI cycle: the write lands at that edge and the scan sees the new value.
- Wr_En outside INI is dropped; the array is unchanged.
- Ack held high continuously completes INI on the next cycle. A new scan needs Start again.
- All outputs are registered except Done and Q*, which decode the state register.

## Structure
- Shared package lnd_pkg holds:
  - the five state encodings as localparams;
  - MODE_MAX=0 and MODE_MIN=1;
  - a clog2 function.
- Natural sub-module: lnd_array_mem, the DEPTH×WIDTH register array.
  - Ports: Clk, write port, and asynchronous read on I.
  - No reset.
- The FSM and datapath sit in one clocked block, in the same style as the existing exercise blocks.

## Test plan
- Default params, array {14,3,0,49,21,50,...0}, Mode=0 → D_F, Result=49, Result_Idx=3, Count=3.
- Same array, Mode=1 → Result=14, Result_Idx=0, Count=3.
- All entries zero or non-multiples, e.g. {0,1,8,...} → D_NF, Result=0, Count=0. Ack → Qi=1 next cycle.
- Tie test: M[2]=M[9]=70, Mode=0 → Result_Idx=2.
- WIDTH=12, DEPTH=8, DIVISOR=13, M[7]=4095=13·315, other entries non-multiples.
  - Expect Result=4095, Result_Idx=7.
  - Entry-7 latency is 317 cycles.
- Reset_n=0 for one cycle during DIV of entry 5:
  - expect Qi=1 and Result=0 next cycle, array intact;
  - a rescan gives the same answer as an uninterrupted run.
- Wr_En pulsed in DIV is ignored. Wr_En with Start in INI is used by the scan.

Source files
------------

// File: rtl/lnd_pkg.sv
// Shared types and constants for the divisible-by-k search engine.
// State encodings, search modes and a constant clog2 helper.
package lnd_pkg;

    localparam logic [4:0] S_INI  = 5'b00001;
    localparam logic [4:0] S_LD_X = 5'b00010;
    localparam logic [4:0] S_DIV  = 5'b00100;
    localparam logic [4:0] S_D_F  = 5'b01000;
    localparam logic [4:0] S_D_NF = 5'b10000;

    typedef enum logic [4:0] {
        ST_INI  = S_INI,
        ST_LD_X = S_LD_X,
        ST_DIV  = S_DIV,
        ST_D_F  = S_D_F,
        ST_D_NF = S_D_NF
    } state_t;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lnd_array_mem.sv
// DEPTH x WIDTH register array, one write port, async read.
// Contents are not reset so they survive an aborted scan.
module lnd_array_mem
    import lnd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [WIDTH-1:0]  Wr_Data,
    input  logic [ADDR_W-1:0] Rd_Addr,
    output logic [WIDTH-1:0]  Rd_Data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // write port; gating to the idle state is done by the caller
    always_ff @(posedge Clk) begin
        if (Wr_En) begin
            mem_q[Wr_Addr] <= Wr_Data;
        end
    end

    assign Rd_Data = mem_q[Rd_Addr];

endmodule

// File: rtl/largest_num_divisible_by_k.sv
// Scans an array for the largest/smallest non-zero multiple of DIVISOR
// using repeated subtraction; reports value, index and hit count.
module largest_num_divisible_by_k
    import lnd_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int DIVISOR = 7,
    parameter int ADDR_W  = clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Ack,
    input  logic              Find_Min,
    input  logic              Wr_En,
    input  logic [ADDR_W-1:0] Wr_Addr,
    input  logic [WIDTH-1:0]  Wr_Data,
    output logic [WIDTH-1:0]  Result,
    output logic [ADDR_W-1:0] Result_Idx,
    output logic [ADDR_W:0]   Count,
    output logic              Done,
    output logic              Qi,
    output logic              Ql,
    output logic              Qdiv,
    output logic              Qdf,
    output logic              Qdnf
);

    localparam logic [WIDTH-1:0]  DIV_C = WIDTH'(DIVISOR);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              mode_q, mode_d;

    logic [WIDTH-1:0]  rd_data;
    logic              mem_we;
    logic              hit;
    logic              better;

    assign mem_we = Wr_En && (state_q == ST_INI);

    lnd_array_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .Clk     (Clk),
        .Wr_En   (mem_we),
        .Wr_Addr (Wr_Addr),
        .Wr_Data (Wr_Data),
        .Rd_Addr (i_q),
        .Rd_Data (rd_data)
    );

    // hit/better qualify the current entry once the remainder is final
    always_comb begin
        hit    = (x_q == '0) && (rd_data != '0);
        better = (count_q == '0)
              || ((mode_q == MODE_MAX) && (rd_data > result_q))
              || ((mode_q == MODE_MIN) && (rd_data < result_q));
    end

    // next-state and datapath updates
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        i_d      = i_q;
        result_d = result_q;
        idx_d    = idx_q;
        count_d  = count_q;
        mode_d   = mode_q;
        case (state_q)
            ST_INI: begin
                result_d = '0;
                idx_d    = '0;
                count_d  = '0;
                i_d      = '0;
                if (Start) begin
                    mode_d  = Find_Min;
                    state_d = ST_LD_X;
                end
            end
            ST_LD_X: begin
                x_d     = rd_data;
                state_d = ST_DIV;
            end
            ST_DIV: begin
                if (x_q >= DIV_C) begin
                    x_d = x_q - DIV_C;
                end else begin
                    if (hit) begin
                        count_d = count_q + 1'b1;
                        if (better) begin
                            result_d = rd_data;
                            idx_d    = i_q;
                        end
                    end
                    if (i_q == LAST) begin
                        if ((count_q != '0) || hit) begin
                            state_d = ST_D_F;
                        end else begin
                            state_d = ST_D_NF;
                        end
                    end else begin
                        i_d     = i_q + 1'b1;
                        state_d = ST_LD_X;
                    end
                end
            end
            ST_D_F, ST_D_NF: begin
                if (Ack) begin
                    state_d = ST_INI;
                end
            end
            default: begin
                state_d = ST_INI;
            end
        endcase
    end

    // state and datapath registers, synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q  <= ST_INI;
            x_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            mode_q   <= MODE_MAX;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            i_q      <= i_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
        end
    end

    assign Result     = result_q;
    assign Result_Idx = idx_q;
    assign Count      = count_q;
    assign Qi         = state_q[0];
    assign Ql         = state_q[1];
    assign Qdiv       = state_q[2];
    assign Qdf        = state_q[3];
    assign Qdnf       = state_q[4];
    assign Done       = Qdf | Qdnf;

endmodule

// File: tb/tb_largest_num_divisible_by_k.sv
// Randomised bench with a behavioural model of the divisible-by-k search.
// A second instance covers WIDTH=12, DEPTH=8, DIVISOR=13.
module tb_largest_num_divisible_by_k;

    logic       clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Start = 1'b0, Ack = 1'b0, Find_Min = 1'b0, Wr_En = 1'b0;
    logic [3:0] Wr_Addr = '0;
    logic [7:0] Wr_Data = '0;
    logic [7:0] Result;
    logic [3:0] Result_Idx;
    logic [4:0] Count;
    logic       Done, Qi, Ql, Qdiv, Qdf, Qdnf;

    logic        s2_start = 1'b0, s2_ack = 1'b0, s2_fmin = 1'b0, s2_we = 1'b0;
    logic [2:0]  s2_addr = '0;
    logic [11:0] s2_data = '0;
    logic [11:0] s2_res;
    logic [2:0]  s2_idx;
    logic [3:0]  s2_cnt;
    logic        s2_done, s2_qi, s2_ql, s2_qdiv, s2_qdf, s2_qdnf;

    always #5 clk = ~clk;

    largest_num_divisible_by_k u_dut (
        .Clk(clk), .Reset_n(Reset_n), .Start(Start), .Ack(Ack),
        .Find_Min(Find_Min), .Wr_En(Wr_En), .Wr_Addr(Wr_Addr),
        .Wr_Data(Wr_Data), .Result(Result), .Result_Idx(Result_Idx),
        .Count(Count), .Done(Done), .Qi(Qi), .Ql(Ql), .Qdiv(Qdiv),
        .Qdf(Qdf), .Qdnf(Qdnf)
    );

    largest_num_divisible_by_k #(
        .WIDTH(12), .DEPTH(8), .DIVISOR(13)
    ) u_dut2 (
        .Clk(clk), .Reset_n(Reset_n), .Start(s2_start), .Ack(s2_ack),
        .Find_Min(s2_fmin), .Wr_En(s2_we), .Wr_Addr(s2_addr),
        .Wr_Data(s2_data), .Result(s2_res), .Result_Idx(s2_idx),
        .Count(s2_cnt), .Done(s2_done), .Qi(s2_qi), .Ql(s2_ql),
        .Qdiv(s2_qdiv), .Qdf(s2_qdf), .Qdnf(s2_qdnf)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mdl_mem [16];
    logic [7:0] exp_r;
    logic [3:0] exp_idx;
    logic [4:0] exp_cnt;
    logic       exp_found;
    bit         chk_on = 1'b0;
    bit         prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // reference: plain search over the model array
    task automatic model(input bit mode);
        exp_r = '0;
        exp_idx = '0;
        exp_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            if (mdl_mem[i] != 0 && (mdl_mem[i] % 7) == 0) begin
                if (exp_cnt == 0 ||
                    (mode ? (mdl_mem[i] < exp_r) : (mdl_mem[i] > exp_r))) begin
                    exp_r = mdl_mem[i];
                    exp_idx = 4'(i);
                end
                exp_cnt++;
            end
        end
        exp_found = (exp_cnt != 0);
    endtask

    function automatic int latency();
        int s;
        s = 1;
        for (int i = 0; i < 16; i++) s += 2 + int'(mdl_mem[i]) / 7;
        return s;
    endfunction

    // every-cycle compare against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("onehot", $countones({Qdnf, Qdf, Qdiv, Ql, Qi}), 1);
            if (Qi && !prev_done) begin
                chk("ini_result", Result, 0);
                chk("ini_idx", Result_Idx, 0);
                chk("ini_count", Count, 0);
            end
            if (Done) begin
                chk("result", Result, exp_r);
                chk("result_idx", Result_Idx, exp_idx);
                chk("count", Count, exp_cnt);
                chk("qdf", Qdf, exp_found);
                chk("qdnf", Qdnf, !exp_found);
            end
            prev_done = Done;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        Wr_En = 1'b1;
        Wr_Addr = a;
        Wr_Data = d;
        tick();
        Wr_En = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic scan(input bit mode, input bit wr_start, input bit wr_div,
                        input bit lit, input int lr, input int li, input int lc);
        int  cyc, lat;
        bit  pulsed;
        logic [3:0] a;
        Find_Min = mode;
        Start = 1'b1;
        if (wr_start) begin
            a = 4'($urandom);
            Wr_En = 1'b1;
            Wr_Addr = a;
            Wr_Data = 8'($urandom);
            mdl_mem[a] = Wr_Data;
        end
        model(mode);
        lat = latency();
        tick();
        Start = 1'b0;
        Wr_En = 1'b0;
        Find_Min = 1'($urandom);
        cyc = 1;
        pulsed = 1'b0;
        while (!Done && cyc < 5000) begin
            Wr_En = 1'b0;
            if (wr_div && !pulsed && Qdiv) begin
                Wr_En = 1'b1;
                Wr_Addr = 4'($urandom);
                Wr_Data = 8'($urandom);
                pulsed = 1'b1;
            end
            tick();
            cyc++;
        end
        Wr_En = 1'b0;
        if (!Done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scan_timeout: no Done after %0d cycles", cyc);
        end else begin
            chk("scan_latency", cyc, lat);
            if (lit) begin
                chk("lit_result", Result, lr);
                chk("lit_idx", Result_Idx, li);
                chk("lit_count", Count, lc);
            end
        end
        repeat ($urandom_range(0, 2)) begin
            Start = 1'($urandom);
            Wr_En = 1'b1;
            Wr_Addr = 4'($urandom);
            Wr_Data = 8'($urandom);
            tick();
        end
        Start = 1'b0;
        Wr_En = 1'b0;
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk("ack_to_ini", Qi, 1);
    endtask

    initial begin
        int n_ld, cyc, since;
        logic [7:0] v;

        repeat (2) tick();
        Reset_n = 1'b1;
        chk("rst_qi", Qi, 1);
        chk("rst_done", Done, 0);
        chk("rst_result", Result, 0);
        chk("rst_count", Count, 0);
        chk("rst2_qi", s2_qi, 1);
        chk_on = 1'b1;

        for (int i = 0; i < 16; i++) wr(4'(i), 8'd0);
        wr(0, 14); wr(1, 3); wr(3, 49); wr(4, 21); wr(5, 50);
        scan(0, 0, 0, 1, 49, 3, 3);
        scan(1, 0, 0, 1, 14, 0, 3);

        for (int i = 0; i < 16; i++) wr(4'(i), (i == 0) ? 8'd0 : 8'(7 * i - 6));
        scan(0, 0, 0, 1, 0, 0, 0);
        chk("nf_found", exp_found, 0);

        wr(2, 70); wr(9, 70);
        scan(0, 0, 0, 1, 70, 2, 2);
        scan(1, 0, 1, 1, 70, 2, 2);
        scan(0, 0, 0, 1, 70, 2, 2);

        wr(5, 49);
        Find_Min = 1'b0;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        n_ld = 0;
        cyc = 0;
        while (cyc < 2000) begin
            if (Ql) n_ld++;
            if (Qdiv && n_ld == 6) break;
            tick();
            cyc++;
        end
        chk("reached_div5", Qdiv, 1);
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        chk("midrst_qi", Qi, 1);
        chk("midrst_result", Result, 0);
        scan(0, 0, 0, 1, 70, 2, 3);

        scan(0, 1, 0, 0, 0, 0, 0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 2))
                    0: v = 8'd0;
                    1: v = 8'(7 * $urandom_range(1, 36));
                    default: v = 8'($urandom);
                endcase
                wr(4'(i), v);
            end
            scan(1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0);
        end

        for (int i = 0; i < 7; i++) begin
            s2_we = 1'b1;
            s2_addr = 3'(i);
            s2_data = 12'(i + 1);
            tick();
        end
        s2_addr = 3'd7;
        s2_data = 12'd4095;
        tick();
        s2_we = 1'b0;
        s2_fmin = 1'b0;
        s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        cyc = 1;
        since = 0;
        while (!s2_done && cyc < 2000) begin
            if (s2_ql) since = 1;
            else if (s2_qdiv) since++;
            tick();
            cyc++;
        end
        chk("w12_total_latency", cyc, 332);
        chk("w12_entry7_latency", since, 317);
        chk("w12_result", s2_res, 4095);
        chk("w12_idx", s2_idx, 7);
        chk("w12_count", s2_cnt, 1);
        chk("w12_qdf", s2_qdf, 1);
        s2_ack = 1'b1;
        tick();
        s2_ack = 1'b0;
        chk("w12_ack", s2_qi, 1);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
